issue_control_unit: RTL and testbench
=====================================

# issue_control_unit

Parametrised in-order issue controller between the instruction front end's queue head and the core's execution units (ALU, PFCU, LSU, and any added later). It classifies the head micro-op by opcode class and stalls until the scoreboard marks all used source physical registers valid. It then holds a one-hot enable to the matching unit until that unit reports done, and pops the queue. It also adds flush, a done-timeout with halt, illegal-class retirement and performance counters.

## Interface
- NUM_EU, 3: number of execution units.
- EU_CLASS, {3'b010,3'b110,3'b100}: packed NUM_EU×3; entry k is the opcode class (uop bits [2:0]) handled by EU k. Default maps EU0 to ALU (100), EU1 to PFCU (110) and EU2 to LSU (010).
- NUM_PHYSICAL_REGS, 64: scoreboard size; PRW = $clog2(NUM_PHYSICAL_REGS).
- NUM_SRC, 4: source operand slots per micro-op.
- UOP_W, 32: micro-op width.
- TIMEOUT, 1024: maximum EXEC cycles without done; must be ≥ 2.
- cclk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the current micro-op.
- iq_ip  in  1  queue head valid.
- iq_uop  in  UOP_W  head micro-op.
- iq_src  in  NUM_SRC×PRW  head source physical registers.
- iq_src_use  in  NUM_SRC  per-slot "source used".
- iq_pop  out  1  one-cycle pop of the queue head.
- sb_pr_valid  in  NUM_PHYSICAL_REGS  scoreboard valid bits.
- eu_en  out  NUM_EU  one-hot unit enable.
- eu_dn  in  NUM_EU  unit done.
- busy  out  1  high whenever state ≠ IDLE.
- err_illegal  out  1  sticky illegal-class flag.
- err_timeout  out  1  sticky timeout flag.
- stall_cnt  out  16  saturating operand-stall cycle counter.
- issue_cnt  out  32  wrapping retired-uop counter.

## Operation
- States: IDLE, WAIT, EXEC, POP, ILLEGAL, HALT.
- Reset (rst=0): state IDLE; eu_en=0, iq_pop=0, busy=0, err_illegal=0, err_timeout=0, stall_cnt=0, issue_cnt=0; the selected-EU index and the timeout counter are cleared.
- IDLE:
  - iq_ip=1 and some EU_CLASS[k] equals iq_uop[2:0]: latch k (lowest k wins on multiple matches) and go to WAIT.
  - iq_ip=1 and no EU matches: go to ILLEGAL.
  - iq_ip=0: stay in IDLE.
- WAIT: ready = AND over slots i of (!iq_src_use[i] | sb_pr_valid[iq_src[i]]).
  - ready=1: go to EXEC.
  - ready=0: stall_cnt increments, saturating at 16'hFFFF.
- EXEC: eu_en = one-hot(k), registered.
  - eu_dn[k]=1: go to POP.
  - eu_dn from any other EU is ignored.
  - The timeout counter increments each EXEC cycle. If it reaches TIMEOUT-1 with no done, set err_timeout, drop eu_en and go to HALT.
- POP: iq_pop=1 for exactly one cycle, eu_en=0, issue_cnt+1 (wraps), then IDLE.
- ILLEGAL: iq_pop=1 for one cycle, set err_illegal, issue_cnt is unchanged, then IDLE.
- HALT: all outputs idle except busy=1; the only exits are flush or reset.
- Flush: highest priority after reset. From any state, the next state is IDLE with eu_en=0 and no pop. The error flags and counters are retained.
- The iq_* inputs must stay stable from IDLE exit until the pop. The block samples them live and does not re-latch them.

## Timing
- All outputs are registered from state; no combinational path from inputs to outputs.
- Best case, cycle 0 is IDLE with iq_ip=1 and class matched:
  - cycle 1: WAIT;
  - cycle 2: EXEC, eu_en high;
  - eu_dn sampled high in cycle 2: cycle 3 is POP with iq_pop high;
  - cycle 4: IDLE.
- Throughput: 4 cycles per micro-op, plus stall cycles, plus done latency.
- eu_en stays high through the cycle in which eu_dn is sampled and falls in POP. This prevents the PFCU/LSU from double-submitting.
- A timeout counted from the first EXEC cycle sets err_timeout visible at cycle first+TIMEOUT.
- eu_dn arriving in the same cycle as the timeout threshold: done wins, the block goes to POP, and no error is raised.
- Flush and eu_dn in the same cycle: flush wins and there is no pop.
- Reset asserted mid-EXEC: eu_en falls asynchronously.

## Test plan
- ALU uop (class 100), sources valid, eu_dn[0] one cycle after eu_en -> eu_en=3'b001 for 2 cycles, iq_pop pulse at cycle 4, issue_cnt=1.
- PFCU uop with src0=PR 5, sb_pr_valid[5] low for 7 cycles -> stall_cnt=7, eu_en=3'b010 only after PR 5 becomes valid, one pop.
- Uop class 111 -> single iq_pop pulse, err_illegal=1, no eu_en, issue_cnt unchanged.
- TIMEOUT=8, LSU never sets done -> eu_en=3'b100 for 8 cycles, err_timeout=1, state HALT with busy=1; then a flush -> IDLE, flag retained.
- Flush while in EXEC simultaneous with eu_dn -> no pop, eu_en=0 next cycle, issue_cnt unchanged.
- 65536 stall cycles -> stall_cnt holds at 16'hFFFF; async reset mid-run -> every output returns to 0 without a clock edge.

Source files
------------

// File: rtl/issue_control_unit.sv
// In-order issue controller: waits for the queue head's source operands, drives a one-hot
// enable to the execution unit that owns the opcode class, and pops the head once that unit is done.
module issue_control_unit #(
    parameter int                  NUM_EU            = 3,
    parameter logic [NUM_EU*3-1:0] EU_CLASS          = {3'b010, 3'b110, 3'b100},
    parameter int                  NUM_PHYSICAL_REGS = 64,
    parameter int                  NUM_SRC           = 4,
    parameter int                  UOP_W             = 32,
    parameter int                  TIMEOUT           = 1024
) (
    input  logic                                          cclk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_i,
    input  logic                                          iq_ip_i,
    input  logic [UOP_W-1:0]                              iq_uop_i,
    input  logic [NUM_SRC*$clog2(NUM_PHYSICAL_REGS)-1:0]  iq_src_i,
    input  logic [NUM_SRC-1:0]                            iq_src_use_i,
    output logic                                          iq_pop_o,
    input  logic [NUM_PHYSICAL_REGS-1:0]                  sb_pr_valid_i,
    output logic [NUM_EU-1:0]                             eu_en_o,
    input  logic [NUM_EU-1:0]                             eu_dn_i,
    output logic                                          busy_o,
    output logic                                          err_illegal_o,
    output logic                                          err_timeout_o,
    output logic [15:0]                                   stall_cnt_o,
    output logic [31:0]                                   issue_cnt_o
);

    localparam int PRW  = $clog2(NUM_PHYSICAL_REGS);
    localparam int SELW = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;
    localparam int TMW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_EXEC,
        S_POP,
        S_ILLEGAL,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [TMW-1:0]    tmo_q, tmo_d;
    logic [15:0]       stall_q, stall_d;
    logic [31:0]       issue_q, issue_d;
    logic              ill_q, ill_d;
    logic              to_q, to_d;
    logic              pop_q, pop_d;
    logic              busy_q, busy_d;
    logic [NUM_EU-1:0] en_q, en_d;

    logic [NUM_EU-1:0]  cls_match;
    logic [NUM_SRC-1:0] src_ok;
    logic               any_match;
    logic [SELW-1:0]    match_idx;
    logic               ready;

    // Only the class bits of the micro-op matter here; the rest belongs to the units.
    logic unused_uop_bits;
    assign unused_uop_bits = ^iq_uop_i[UOP_W-1:3];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EU; gi++) begin : g_class
            assign cls_match[gi] = (iq_uop_i[2:0] == EU_CLASS[gi*3 +: 3]);
        end
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_ok[gi] = !iq_src_use_i[gi] | sb_pr_valid_i[iq_src_i[gi*PRW +: PRW]];
        end
    endgenerate

    assign any_match = |cls_match;
    assign ready     = &src_ok;

    // Scan downwards so the lowest-numbered matching unit is the one that sticks.
    always_comb begin
        match_idx = '0;
        for (int k = NUM_EU - 1; k >= 0; k--) begin
            if (cls_match[k]) begin
                match_idx = SELW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tmo_d   = tmo_q;
        stall_d = stall_q;
        issue_d = issue_q;
        ill_d   = ill_q;
        to_d    = to_q;

        if (flush_i) begin
            state_d = S_IDLE;
            tmo_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iq_ip_i) begin
                        if (any_match) begin
                            sel_d   = match_idx;
                            state_d = S_WAIT;
                        end else begin
                            ill_d   = 1'b1;
                            state_d = S_ILLEGAL;
                        end
                    end
                end
                S_WAIT: begin
                    if (ready) begin
                        tmo_d   = '0;
                        state_d = S_EXEC;
                    end else if (stall_q != 16'hFFFF) begin
                        stall_d = stall_q + 16'd1;
                    end
                end
                S_EXEC: begin
                    // A done arriving on the threshold cycle still wins over the timeout.
                    if (eu_dn_i[sel_q]) begin
                        issue_d = issue_q + 32'd1;
                        state_d = S_POP;
                    end else if (tmo_q == TMO_LAST) begin
                        to_d    = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        tmo_d = tmo_q + TMW'(1);
                    end
                end
                S_POP:     state_d = S_IDLE;
                S_ILLEGAL: state_d = S_IDLE;
                S_HALT:    state_d = S_HALT;
                default:   state_d = S_IDLE;
            endcase
        end

        pop_d  = (state_d == S_POP) || (state_d == S_ILLEGAL);
        busy_d = (state_d != S_IDLE);
        en_d   = (state_d == S_EXEC) ? (NUM_EU'(1) << sel_d) : '0;
    end

    always_ff @(posedge cclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            tmo_q   <= '0;
            stall_q <= '0;
            issue_q <= '0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
            issue_q <= issue_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
            pop_q   <= pop_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
        end
    end

    assign iq_pop_o      = pop_q;
    assign eu_en_o       = en_q;
    assign busy_o        = busy_q;
    assign err_illegal_o = ill_q;
    assign err_timeout_o = to_q;
    assign stall_cnt_o   = stall_q;
    assign issue_cnt_o   = issue_q;

endmodule

// File: tb/tb_issue_control_unit.sv
// Scenario bench for issue_control_unit: each expected pop is queued when its micro-op is
// presented and checked when the DUT pulses iq_pop.
module tb_issue_control_unit;

    localparam int NUM_EU = 3;
    localparam int NPR    = 64;
    localparam int PRW    = 6;
    localparam int NSRC   = 4;
    localparam int UOP_W  = 32;
    localparam int TMO    = 8;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 flush = 1'b0;
    logic                 iq_ip = 1'b0;
    logic [UOP_W-1:0]     iq_uop = '0;
    logic [NSRC*PRW-1:0]  iq_src = '0;
    logic [NSRC-1:0]      iq_src_use = '0;
    logic                 iq_pop_o;
    logic [NPR-1:0]       sb_pr_valid = '1;
    logic [NUM_EU-1:0]    eu_en_o;
    logic [NUM_EU-1:0]    eu_dn = '0;
    logic                 busy_o;
    logic                 err_illegal_o;
    logic                 err_timeout_o;
    logic [15:0]          stall_cnt_o;
    logic [31:0]          issue_cnt_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_issue = 0;

    typedef struct {
        logic [2:0]  en;
        logic        ill;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    issue_control_unit #(
        .NUM_EU(NUM_EU), .EU_CLASS({3'b010, 3'b110, 3'b100}), .NUM_PHYSICAL_REGS(NPR),
        .NUM_SRC(NSRC), .UOP_W(UOP_W), .TIMEOUT(TMO)
    ) dut (
        .cclk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .iq_ip_i(iq_ip), .iq_uop_i(iq_uop),
        .iq_src_i(iq_src), .iq_src_use_i(iq_src_use), .iq_pop_o(iq_pop_o),
        .sb_pr_valid_i(sb_pr_valid), .eu_en_o(eu_en_o), .eu_dn_i(eu_dn), .busy_o(busy_o),
        .err_illegal_o(err_illegal_o), .err_timeout_o(err_timeout_o),
        .stall_cnt_o(stall_cnt_o), .issue_cnt_o(issue_cnt_o)
    );

    task automatic set_uop(input logic [2:0] cls, input logic [NSRC-1:0] use_v,
                           input logic [NSRC*PRW-1:0] srcs);
        iq_uop      = $urandom();
        iq_uop[2:0] = cls;
        iq_src      = srcs;
        iq_src_use  = use_v;
        iq_ip       = 1'b1;
    endtask

    // Runs negedge by negedge until a pop, answering each enabled cycle with dn_mask.
    task automatic wait_pop(input int max_cyc, input logic [2:0] dn_mask, output bit seen,
                            output logic [2:0] en_or, output int en_cyc, output int cyc);
        seen = 0; en_or = '0; en_cyc = 0; cyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            cyc++;
            if (iq_pop_o) begin
                seen  = 1;
                iq_ip = 1'b0;
                eu_dn = '0;
                break;
            end
            if (eu_en_o != '0) begin
                en_or  = en_or | eu_en_o;
                en_cyc++;
                eu_dn  = dn_mask;
            end else begin
                eu_dn = '0;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({iq_pop_o, eu_en_o, busy_o, err_illegal_o, err_timeout_o, stall_cnt_o, issue_cnt_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got pop=%b en=%b busy=%b ill=%b to=%b stall=%0d issue=%0d, want all 0",
                     iq_pop_o, eu_en_o, busy_o, err_illegal_o, err_timeout_o, stall_cnt_o, issue_cnt_o);
        end
        $display("reset: outputs pop=%b en=%b busy=%b", iq_pop_o, eu_en_o, busy_o);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_alu();
        exp_t e;
        @(negedge clk);
        set_uop(3'b100, 4'b1111, {6'd1, 6'd2, 6'd3, 6'd4});
        sb_q.push_back('{en: 3'b001, ill: 1'b0, cnt: exp_issue + 1});
        @(negedge clk);
        total++;
        if (busy_o !== 1'b1 || eu_en_o !== 3'b000) begin
            bad++;
            $display("FAIL alu_wait: got busy=%b en=%b, want busy=1 en=000", busy_o, eu_en_o);
        end
        @(negedge clk);
        total++;
        if (eu_en_o !== 3'b001) begin
            bad++;
            $display("FAIL alu_en_first: got en=%b, want 001", eu_en_o);
        end
        eu_dn = 3'b110;
        @(negedge clk);
        total++;
        if (eu_en_o !== 3'b001 || iq_pop_o !== 1'b0) begin
            bad++;
            $display("FAIL alu_foreign_done: got en=%b pop=%b, want en=001 pop=0", eu_en_o, iq_pop_o);
        end
        eu_dn = 3'b001;
        @(negedge clk);
        eu_dn = '0;
        iq_ip = 1'b0;
        total++;
        if (iq_pop_o !== 1'b1 || eu_en_o !== 3'b000) begin
            bad++;
            $display("FAIL alu_pop_cycle4: got pop=%b en=%b, want pop=1 en=000", iq_pop_o, eu_en_o);
        end
        e = sb_q.pop_front();
        total++;
        if (issue_cnt_o !== e.cnt || err_illegal_o !== e.ill) begin
            bad++;
            $display("FAIL alu_sb: got issue=%0d ill=%b, want issue=%0d ill=%b", issue_cnt_o, err_illegal_o, e.cnt, e.ill);
        end
        exp_issue = e.cnt;
        @(negedge clk);
        total++;
        if (iq_pop_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL alu_idle: got pop=%b busy=%b, want 0 0", iq_pop_o, busy_o);
        end
        $display("alu: issue_cnt=%0d", issue_cnt_o);
    endtask

    task automatic test_pfcu_stall();
        exp_t e; bit seen; logic [2:0] en_or; int en_cyc; int cyc; bit early_en;
        early_en = 0;
        @(negedge clk);
        sb_pr_valid[5]  = 1'b0;
        sb_pr_valid[17] = 1'b0;
        set_uop(3'b110, 4'b0101, {6'd33, 6'd9, 6'd17, 6'd5});
        sb_q.push_back('{en: 3'b010, ill: 1'b0, cnt: exp_issue + 1});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (eu_en_o !== 3'b000) early_en = 1;
        end
        total++;
        if (early_en) begin
            bad++;
            $display("FAIL pfcu_early_en: got enable while PR5 invalid, want none");
        end
        total++;
        if (stall_cnt_o !== 16'd7) begin
            bad++;
            $display("FAIL pfcu_stall_cnt: got %0d, want 7", stall_cnt_o);
        end
        sb_pr_valid[5] = 1'b1;
        wait_pop(10, 3'b010, seen, en_or, en_cyc, cyc);
        e = sb_q.pop_front();
        total++;
        if (!seen || en_or !== e.en || issue_cnt_o !== e.cnt) begin
            bad++;
            $display("FAIL pfcu_sb: got seen=%0d en=%b issue=%0d, want seen=1 en=%b issue=%0d", seen, en_or, issue_cnt_o, e.en, e.cnt);
        end
        exp_issue = e.cnt;
        @(negedge clk);
        total++;
        if (iq_pop_o !== 1'b0 || stall_cnt_o !== 16'd7) begin
            bad++;
            $display("FAIL pfcu_single_pop: got pop=%b stall=%0d, want pop=0 stall=7", iq_pop_o, stall_cnt_o);
        end
        sb_pr_valid = '1;
        $display("pfcu: stall_cnt=%0d issue_cnt=%0d", stall_cnt_o, issue_cnt_o);
    endtask

    task automatic test_illegal();
        exp_t e;
        @(negedge clk);
        set_uop(3'b111, 4'b0000, '0);
        sb_q.push_back('{en: 3'b000, ill: 1'b1, cnt: exp_issue});
        @(negedge clk);
        iq_ip = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (iq_pop_o !== 1'b1 || eu_en_o !== e.en || err_illegal_o !== e.ill || issue_cnt_o !== e.cnt) begin
            bad++;
            $display("FAIL illegal_pop: got pop=%b en=%b ill=%b issue=%0d, want pop=1 en=%b ill=%b issue=%0d",
                     iq_pop_o, eu_en_o, err_illegal_o, issue_cnt_o, e.en, e.ill, e.cnt);
        end
        @(negedge clk);
        total++;
        if (iq_pop_o !== 1'b0 || err_illegal_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL illegal_after: got pop=%b ill=%b busy=%b, want 0 1 0", iq_pop_o, err_illegal_o, busy_o);
        end
        $display("illegal: err_illegal=%b issue_cnt=%0d", err_illegal_o, issue_cnt_o);
    endtask

    task automatic test_done_at_threshold();
        exp_t e; int en_cyc; bit seen;
        en_cyc = 0; seen = 0;
        @(negedge clk);
        set_uop(3'b010, 4'b1111, {6'd7, 6'd8, 6'd9, 6'd10});
        sb_q.push_back('{en: 3'b100, ill: 1'b0, cnt: exp_issue + 1});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (iq_pop_o) begin
                seen = 1;
                break;
            end
            if (eu_en_o != '0) en_cyc++;
            eu_dn = (en_cyc == TMO) ? 3'b100 : 3'b000;
        end
        eu_dn = '0;
        iq_ip = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (!seen || en_cyc != TMO || issue_cnt_o !== e.cnt || err_timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL threshold_done: got seen=%0d en_cycles=%0d issue=%0d to=%b, want seen=1 en_cycles=%0d issue=%0d to=0",
                     seen, en_cyc, issue_cnt_o, err_timeout_o, TMO, e.cnt);
        end
        exp_issue = e.cnt;
        $display("threshold: en_cycles=%0d err_timeout=%b", en_cyc, err_timeout_o);
    endtask

    task automatic test_timeout_halt();
        bit seen; logic [2:0] en_or; int en_cyc; int cyc;
        @(negedge clk);
        set_uop(3'b010, 4'b0000, '0);
        wait_pop(20, 3'b000, seen, en_or, en_cyc, cyc);
        iq_ip = 1'b0;
        total++;
        if (seen || en_cyc != TMO || en_or !== 3'b100) begin
            bad++;
            $display("FAIL timeout_en: got pop_seen=%0d en_cycles=%0d en=%b, want 0 %0d 100", seen, en_cyc, en_or, TMO);
        end
        total++;
        if (err_timeout_o !== 1'b1 || busy_o !== 1'b1 || eu_en_o !== 3'b000 || iq_pop_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_halt: got to=%b busy=%b en=%b pop=%b, want 1 1 000 0", err_timeout_o, busy_o, eu_en_o, iq_pop_o);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy_o !== 1'b0 || err_timeout_o !== 1'b1 || issue_cnt_o !== exp_issue) begin
            bad++;
            $display("FAIL timeout_flush: got busy=%b to=%b issue=%0d, want 0 1 %0d", busy_o, err_timeout_o, issue_cnt_o, exp_issue);
        end
        $display("timeout: en_cycles=%0d err_timeout=%b", en_cyc, err_timeout_o);
    endtask

    task automatic test_flush_done();
        bit got_en; bit stray_pop;
        got_en = 0; stray_pop = 0;
        @(negedge clk);
        set_uop(3'b100, 4'b0000, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (eu_en_o != '0) begin
                got_en = 1;
                break;
            end
        end
        flush = 1'b1;
        eu_dn = 3'b001;
        iq_ip = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        eu_dn = '0;
        total++;
        if (!got_en || eu_en_o !== 3'b000 || iq_pop_o !== 1'b0 || busy_o !== 1'b0 || issue_cnt_o !== exp_issue) begin
            bad++;
            $display("FAIL flush_vs_done: got en_seen=%0d en=%b pop=%b busy=%b issue=%0d, want 1 000 0 0 %0d",
                     got_en, eu_en_o, iq_pop_o, busy_o, issue_cnt_o, exp_issue);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (iq_pop_o) stray_pop = 1;
        end
        total++;
        if (stray_pop) begin
            bad++;
            $display("FAIL flush_no_pop: got a pop after flush, want none");
        end
        $display("flush: issue_cnt=%0d", issue_cnt_o);
    endtask

    task automatic test_back_to_back();
        logic [2:0] cls_tab [3];
        logic [2:0] en_tab  [3];
        exp_t e; bit seen; logic [2:0] en_or; int en_cyc; int cyc;
        cls_tab = '{3'b100, 3'b110, 3'b010};
        en_tab  = '{3'b001, 3'b010, 3'b100};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            set_uop(cls_tab[t], 4'(t + 1), {6'd11, 6'd22, 6'd33, 6'd44});
            sb_q.push_back('{en: en_tab[t], ill: 1'b0, cnt: exp_issue + 1});
            wait_pop(10, en_tab[t], seen, en_or, en_cyc, cyc);
            e = sb_q.pop_front();
            total++;
            if (!seen || en_or !== e.en || issue_cnt_o !== e.cnt || cyc != 3) begin
                bad++;
                $display("FAIL b2b_%0d: got seen=%0d en=%b issue=%0d latency=%0d, want 1 %b %0d 3",
                         t, seen, en_or, issue_cnt_o, cyc, e.en, e.cnt);
            end
            exp_issue = e.cnt;
            $display("b2b %0d: class=%b en=%b latency=%0d issue=%0d", t, cls_tab[t], en_or, cyc, issue_cnt_o);
        end
    endtask

    task automatic test_saturate_and_async_reset();
        @(negedge clk);
        sb_pr_valid[5] = 1'b0;
        set_uop(3'b110, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd5});
        for (int i = 0; i < 65540; i++) @(negedge clk);
        total++;
        if (stall_cnt_o !== 16'hFFFF || busy_o !== 1'b1 || eu_en_o !== 3'b000) begin
            bad++;
            $display("FAIL stall_saturate: got stall=%h busy=%b en=%b, want ffff 1 000", stall_cnt_o, busy_o, eu_en_o);
        end
        sb_pr_valid[5] = 1'b1;
        @(negedge clk);
        total++;
        if (eu_en_o !== 3'b010 || stall_cnt_o !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_exec: got en=%b stall=%h, want 010 ffff", eu_en_o, stall_cnt_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({iq_pop_o, eu_en_o, busy_o, err_illegal_o, err_timeout_o, stall_cnt_o, issue_cnt_o} !== '0) begin
            bad++;
            $display("FAIL async_reset: got pop=%b en=%b busy=%b ill=%b to=%b stall=%h issue=%0d, want all 0",
                     iq_pop_o, eu_en_o, busy_o, err_illegal_o, err_timeout_o, stall_cnt_o, issue_cnt_o);
        end
        $display("saturate/reset: en=%b stall=%h", eu_en_o, stall_cnt_o);
        iq_ip = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_pfcu_stall();
        test_illegal();
        test_done_at_threshold();
        test_timeout_halt();
        test_flush_done();
        test_back_to_back();
        test_saturate_and_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
